// File: rtl/uart_rx_fifo_pkg.sv
// Shared defaults, UARTSTAT bit positions and FIFO operation encoding for the UART receive buffer.
package uart_rx_fifo_pkg;

    localparam int unsigned RXFIFO_DEPTH_LOG2_DEF = 4;
    localparam int unsigned RXFIFO_RTS_HIGH_DEF   = 12;
    localparam int unsigned RXFIFO_RTS_LOW_DEF    = 4;

    localparam int unsigned UARTSTAT_RXAVAIL_BIT  = 7;
    localparam int unsigned UARTSTAT_TXBUSY_BIT   = 6;
    localparam int unsigned UARTSTAT_OVERRUN_BIT  = 5;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/uart_rxfifo_ram.sv
// 2**ADDR_W x 8 dual-port distributed RAM: synchronous write, asynchronous read, no reset.
module uart_rxfifo_ram #(
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [7:0]        wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [7:0]        rdata_o
);

    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO with read-edge pop and RTS hysteresis flow control.
// Optional sticky overrun flag enabled by defining UART_RXFIFO_OVERRUN_EN.
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2     = RXFIFO_DEPTH_LOG2_DEF,
    parameter int unsigned RTS_HIGH_WATER = RXFIFO_RTS_HIGH_DEF,
    parameter int unsigned RTS_LOW_WATER  = RXFIFO_RTS_LOW_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          in_data,
    input  logic                in_valid,
    input  logic                rd_req,
    input  logic                flush,
    output logic [7:0]          rd_data,
    output logic                empty,
    output logic                full,
    output logic [DEPTH_LOG2:0] level,
    output logic                rts_n,
    output logic                overrun
);

    localparam int unsigned PTR_W = DEPTH_LOG2;
    localparam int unsigned LVL_W = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             rts_q, rts_d;
    logic             rd_prev_q;
    logic             pop_edge, do_pop, do_push;
    fifo_op_e         op;
    logic [7:0]       ram_rdata;

    assign empty = (level_q == '0);
    assign full  = (level_q == LVL_W'(DEPTH));

    // Pop fires when the CPU read ends, so the head stays stable for the whole read.
    assign pop_edge = rd_prev_q & ~rd_req;
    assign do_pop   = pop_edge & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a push while full is still accepted.
    assign do_push  = in_valid & ~flush & (~full | do_pop);
    assign op       = fifo_op_e'({do_pop, do_push});

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        rts_d    = rts_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            rts_d    = 1'b0;
        end else begin
            case (op)
                OP_PUSH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    level_d  = level_q + LVL_W'(1);
                end
                OP_POP: begin
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    level_d  = level_q - LVL_W'(1);
                end
                OP_BOTH: begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    rd_ptr_d = rd_ptr_q + PTR_W'(1);
                end
                default: ;
            endcase
            if (level_d >= LVL_W'(RTS_HIGH_WATER)) begin
                rts_d = 1'b1;
            end else if (level_d <= LVL_W'(RTS_LOW_WATER)) begin
                rts_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rts_q     <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            rts_q     <= rts_d;
            rd_prev_q <= rd_req;
        end
    end

    uart_rxfifo_ram #(
        .ADDR_W (PTR_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (do_push),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_ptr_q),
        .rdata_o (ram_rdata)
    );

    assign rd_data = empty ? '0 : ram_rdata;
    assign level   = level_q;
    assign rts_n   = rts_q;

`ifdef UART_RXFIFO_OVERRUN_EN
    logic overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (flush) begin
            overrun_d = 1'b0;
        end else if (in_valid & full & ~do_pop) begin
            overrun_d = 1'b1;
        end else if (do_pop) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`else
    assign overrun = 1'b0;
`endif

endmodule
